// File: rtl/seq_restoring_divider_pkg.sv
// div_pkg: shared width, counter sizing, FSM states and constants for seq_restoring_divider.
package div_pkg;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] QUOT_ONES = '1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: operand and result valid/ready handshakes of the divider.
interface seq_restoring_divider_if;
  import div_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [WIDTH-1:0] dividend, divisor, quotient, remainder;
  modport master(
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );
  modport slave(
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider_step.sv
// div_step: one restoring iteration -- shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [WIDTH-1:0] rem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             qbit
);
  logic [WIDTH:0] shifted, diff;
  assign shifted = {rem, dbit};
  assign diff = shifted - {1'b0, divisor};
  assign qbit = ~diff[WIDTH];
  assign rem_nxt = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands and results.
module seq_restoring_divider
  import div_pkg::*;
(
  input logic clk,
  input logic rst_n,
  seq_restoring_divider_if.slave bus
);
  state_t state, nxt;
  logic [WIDTH-1:0] acc, rem, dsr, rem_nxt, q_raw, q_fin, r_fin, cap_a, cap_d;
  logic [CNT_W-1:0] cnt;
  logic dbz, qbit, last, take, zero;
  assign take = state == IDLE && bus.in_valid;
  assign zero = bus.divisor == '0;
  assign last = cnt == CNT_W'(WIDTH - 1);
  // acc holds the dividend and fills with quotient bits from the right as it shifts
  assign q_raw = {acc[WIDTH-2:0], qbit};
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.quotient = acc;
  assign bus.remainder = rem;
  assign bus.div_by_zero = dbz;
  div_step u_step (
    .rem(rem),
    .dbit(acc[WIDTH-1]),
    .divisor(dsr),
    .rem_nxt(rem_nxt),
    .qbit(qbit)
  );
`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;
  assign cap_a = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign cap_d = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
  assign q_fin = last && neg_q ? -q_raw : q_raw;
  assign r_fin = last && neg_r ? -rem_nxt : rem_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (take) begin
      neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      neg_r <= bus.dividend[WIDTH-1];
    end
`else
  assign cap_a = bus.dividend;
  assign cap_d = bus.divisor;
  assign q_fin = q_raw;
  assign r_fin = rem_nxt;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // a zero divisor spends one BUSY cycle with no iteration, giving out_valid one cycle after capture
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.in_valid ? BUSY : IDLE;
      BUSY:    nxt = dbz || last ? DONE : BUSY;
      DONE:    nxt = bus.out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      rem <= '0;
      dsr <= '0;
      cnt <= '0;
      dbz <= 1'b0;
    end else if (take) begin
      acc <= zero ? QUOT_ONES : cap_a;
      rem <= zero ? bus.dividend : '0;
      dsr <= cap_d;
      cnt <= '0;
      dbz <= zero;
    end else if (state == BUSY && !dbz) begin
      acc <= q_fin;
      rem <= r_fin;
      cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed vectors checked against literals and an arithmetic model.
module tb_seq_restoring_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic z;
  } res_t;
  res_t sb[$];
  seq_restoring_divider_if bus();
  seq_restoring_divider dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic res_t model(input logic [7:0] a, input logic [7:0] d);
    res_t e;
`ifdef DIV_SIGNED_EN
    int sa, sd;
    sa = $signed(a);
    sd = $signed(d);
`endif
    if (d == 8'd0) begin
      e.q = 8'hFF;
      e.r = a;
      e.z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      e.q = 8'(sa / sd);
      e.r = 8'(sa % sd);
`else
      e.q = a / d;
      e.r = a % d;
`endif
      e.z = 1'b0;
    end
    return e;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else if (bus.out_valid) begin
      check("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
        check("model_q", 32'(bus.quotient), 32'(sb[0].q));
        check("model_r", 32'(bus.remainder), 32'(sb[0].r));
        check("model_dbz", 32'(bus.div_by_zero), 32'(sb[0].z));
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end
  task automatic send(input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor = d;
    @(posedge clk);
    sb.push_back(model(a, d));
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic run(input logic [7:0] a, input logic [7:0] d, input logic [7:0] eq,
                     input logic [7:0] er, input logic ez, input int elat, input bit toggle,
                     input int hold);
    int lat = 0;
    bus.out_ready = hold == 0;
    send(a, d);
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (toggle) begin
        bus.dividend = 8'($urandom);
        bus.divisor = 8'($urandom);
      end
    end
    check("latency", 32'(lat), 32'(elat));
    check("lit_q", 32'(bus.quotient), 32'(eq));
    check("lit_r", 32'(bus.remainder), 32'(er));
    check("lit_dbz", 32'(bus.div_by_zero), 32'(ez));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_q", 32'(bus.quotient), 32'(eq));
      check("hold_r", 32'(bus.remainder), 32'(er));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_out_valid", 32'(bus.out_valid), 32'd0);
  endtask
  task automatic check_reset_outputs();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_q", 32'(bus.quotient), 32'd0);
    check("rst_r", 32'(bus.remainder), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor = 8'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`ifdef DIV_SIGNED_EN
    run(8'd200, 8'd7, 8'hF8, 8'h00, 1'b0, 8, 1'b0, 0);
`else
    run(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8, 1'b0, 0);
`endif
    run(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1, 1'b0, 0);
    run(8'd255, 8'd1, 8'hFF, 8'd0, 1'b0, 8, 1'b0, 0);
    run(8'd7, 8'd200, 8'd0, 8'd7, 1'b0, 8, 1'b0, 0);
    run(8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 8, 1'b0, 3);
    send(8'd123, 8'd4);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 8, 1'b0, 0);
    run(8'd113, 8'd13, 8'd8, 8'd9, 1'b0, 8, 1'b1, 0);
`ifdef DIV_SIGNED_EN
    run(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 8, 1'b0, 0);
    run(8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 8, 1'b0, 0);
    run(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 8, 1'b0, 0);
    run(8'h9C, 8'h00, 8'hFF, 8'h9C, 1'b1, 1, 1'b0, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
